vector_reduce_unit: RTL and testbench

- Collapses a LANES-wide vector of N-bit elements into one N-bit scalar, using a selectable reduction operator.
- This is the inverse of the immediate-broadcast path: broadcast goes scalar to vector; this block goes vector to scalar.
- Sits between the vector register file read port and the scalar writeback path.
- Iterative design: processes one lane per clock, with valid/ready handshakes on both input and output.

---
 rtl/vector_reduce_unit_if.sv | 26 ++
 rtl/vector_reduce_unit.sv | 148 ++++++++++++++
 tb/tb_vector_reduce_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_reduce_unit_if.sv
// Handshake bundle for vector_reduce_unit: vector-in channel, scalar-out channel and status.
// master drives the vector side and consumes the scalar; slave is the reduce unit itself.
interface vector_reduce_unit_if #(
  parameter int N     = 16,
  parameter int LANES = 16
) ();
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0][N-1:0]     vec_in;
  logic [2:0]                  op;
  logic                        out_valid;
  logic                        out_ready;
  logic [N-1:0]                result;
  logic                        busy;
  logic                        sat;

  modport master (
    output in_valid, vec_in, op, out_ready,
    input  in_ready, out_valid, result, busy, sat
  );

  modport slave (
    input  in_valid, vec_in, op, out_ready,
    output in_ready, out_valid, result, busy, sat
  );
endinterface

// File: rtl/vector_reduce_unit.sv
// Iterative LANES-wide vector to scalar reduction, one lane per clock (IDLE -> ACCUM -> DONE).
// Optional macro VECTOR_REDUCE_SAT_EN makes ADD signed-saturating and drives a sticky sat flag.
module vector_reduce_unit #(
  parameter int N     = 16,
  parameter int LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_reduce_unit_if.slave  bus
);

  localparam int IW = (LANES > 2) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [LANES-1:0][N-1:0] vec_q;
  logic [2:0]              op_q;
  logic [N-1:0]            acc_q;
  logic [IW-1:0]           idx_q;
  logic                    sat_q;
  logic [N-1:0]            result_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;

  logic [N:0]              step_d;

  // One reduction step; the top bit flags a clamped ADD, the low N bits are the new accumulator.
  function automatic logic [N:0] reduce_step(
    input logic [2:0]   op,
    input logic [N-1:0] a,
    input logic [N-1:0] b
  );
    logic [N-1:0] r;
    logic         f;
`ifdef VECTOR_REDUCE_SAT_EN
    logic [N:0]   sum;
    sum = {(N+1){1'b0}};
`endif
    r = a;
    f = 1'b0;
    case (op)
      3'b000: begin
`ifdef VECTOR_REDUCE_SAT_EN
        sum = {a[N-1], a} + {b[N-1], b};
        if (sum[N] != sum[N-1]) begin
          f = 1'b1;
          r = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
          r = sum[N-1:0];
        end
`else
        r = a + b;
`endif
      end
      3'b001: r = a & b;
      3'b010: r = a | b;
      3'b011: r = a ^ b;
      // Ties keep the accumulator, so only a strict win replaces it.
      3'b100: r = ($signed(b) > $signed(a)) ? b : a;
      3'b101: r = ($signed(b) < $signed(a)) ? b : a;
      3'b110: r = (b > a) ? b : a;
      3'b111: r = (b < a) ? b : a;
      default: r = a;
    endcase
    return {f, r};
  endfunction

  // Combine the running accumulator with the lane selected by idx.
  always_comb begin
    step_d = {(N+1){1'b0}};
    step_d = reduce_step(op_q, acc_q, vec_q[idx_q]);
  end

  // Control FSM with all handshake and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= {(LANES*N){1'b0}};
      op_q        <= 3'b000;
      acc_q       <= {N{1'b0}};
      idx_q       <= {IW{1'b0}};
      sat_q       <= 1'b0;
      result_q    <= {N{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            vec_q      <= bus.vec_in;
            op_q       <= bus.op;
            acc_q      <= bus.vec_in[0];
            idx_q      <= IW'(1);
            sat_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          acc_q <= step_d[N-1:0];
          sat_q <= sat_q | step_d[N];
          if (idx_q == IW'(LANES-1)) begin
            idx_q       <= {IW{1'b0}};
            result_q    <= step_d[N-1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          // in_ready rises one cycle after the output handshake, never in the same cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Scoreboard bench for vector_reduce_unit: directed vectors push expected results,
// an independent monitor pops and compares on every output handshake.
module tb_vector_reduce_unit;
  localparam int N     = 16;
  localparam int LANES = 16;

  typedef logic [LANES-1:0][N-1:0] vec_t;
  typedef struct {
    logic [N-1:0] res;
    logic         s;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  vector_reduce_unit_if #(.N(N), .LANES(LANES)) bus ();

  vector_reduce_unit #(.N(N), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t fill(input logic [N-1:0] val);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = val;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input vec_t v, input logic [2:0] o, input logic [N-1:0] er,
                      input logic es, input bit push);
    int n;
    n = 0;
    bus.vec_in   = v;
    bus.op       = o;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (push) exp_q.push_back('{er, es, cyc});
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: latency on out_valid rise, result/sat on each handshake, in_ready right after.
  initial begin
    logic ov_prev;
    exp_t e;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && !ov_prev) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        else chk("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(LANES - 1));
      end
      ov_prev = rst_n ? bus.out_valid : 1'b0;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(bus.result), 32'(e.res));
          chk("sat", 32'(bus.sat), 32'(e.s));
          @(posedge clk); #1;
          chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
          chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
          ov_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t bv[3];
    logic [2:0] bo[3];
    logic [N-1:0] br[3];
    logic [N-1:0] r0;
    int prev_acc;
    int n;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = 3'b000;
    bus.vec_in    = fill(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sat", 32'(bus.sat), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD of 1..16 = 136
    for (int i = 0; i < LANES; i++) v[i] = N'(i + 1);
    send(v, 3'b000, 16'h0088, 1'b0, 1'b1);
    drain();

    // Signed/unsigned MAX/MIN plus logic ops on one 0x7FFF lane among 0x8000
    v = fill(16'h8000);
    v[5] = 16'h7FFF;
    send(v, 3'b100, 16'h7FFF, 1'b0, 1'b1); drain();
    send(v, 3'b111, 16'h7FFF, 1'b0, 1'b1); drain();
    send(v, 3'b110, 16'h8000, 1'b0, 1'b1); drain();
    send(v, 3'b001, 16'h0000, 1'b0, 1'b1); drain();
    send(v, 3'b010, 16'hFFFF, 1'b0, 1'b1); drain();
    send(v, 3'b101, 16'h8000, 1'b0, 1'b1); drain();

    // Asynchronous reset in the middle of an AND reduction
    send(fill(16'hFFFF), 3'b001, 16'h0000, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_sat", 32'(bus.sat), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = fill(16'h0000);
    v[0]  = 16'h0001;
    v[15] = 16'h8000;
    send(v, 3'b010, 16'h8001, 1'b0, 1'b1);
    drain();

    // ADD overflow: wraps by default, clamps with saturation enabled
`ifdef VECTOR_REDUCE_SAT_EN
    send(fill(16'h1000), 3'b000, 16'h7FFF, 1'b1, 1'b1);
`else
    send(fill(16'h1000), 3'b000, 16'h0000, 1'b0, 1'b1);
`endif
    drain();
    send(fill(16'h0000), 3'b000, 16'h0000, 1'b0, 1'b1);
    drain();

    // Backpressure: XOR of alternating halves, held in DONE for 5 cycles with ignored in_valid pulses
    for (int i = 0; i < LANES; i++) v[i] = (i % 2 == 0) ? 16'h00FF : 16'hFF00;
    bus.out_ready = 1'b0;
    send(v, 3'b011, 16'h0000, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid_reached", 32'(bus.out_valid), 32'd1);
    r0 = bus.result;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c == 1 || c == 3);
      bus.vec_in   = fill(16'h1234);
      bus.op       = 3'b000;
      @(posedge clk); #1;
      chk("bp_result", 32'(bus.result), 32'(r0));
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_phantom_busy", 32'(bus.busy), 32'd0);
    chk("bp_no_phantom_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back with in_valid held high: accepts exactly LANES+1 cycles apart
    for (int i = 0; i < LANES; i++) begin
      bv[0][i] = N'(i * 16'h0101);
      bv[1][i] = N'(i * 16'h0100) - 16'h0800;
      bv[2][i] = N'(i + 1);
    end
    bo[0] = 3'b000; br[0] = 16'h7878;
    bo[1] = 3'b101; br[1] = 16'hF800;
    bo[2] = 3'b011; br[2] = 16'h0010;
    prev_acc = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.vec_in = bv[k];
      bus.op     = bo[k];
      n = 0;
      while (!bus.in_ready && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      exp_q.push_back('{br[k], 1'b0, cyc});
      if (k > 0) chk("b2b_spacing", 32'(cyc - prev_acc), 32'(LANES + 1));
      prev_acc = cyc;
    end
    bus.in_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
